work_queue_dispatcher: RTL
==========================

// Module: work_queue_dispatcher
// PURPOSE
//  Consumes 112-bit work-queue entries from the WorkQueue FIFO pop side.
//  Splits each entry into up to 4 data segments and programs one DMA descriptor per segment.
//  Each descriptor is written over an Avalon-MM master: RdDCS for read opcodes, WrDCS for write opcodes.
//  Sits between the queue pair and the PCIe DMA descriptor controller slaves.
// PARAMETERS
//  LEN_SHIFT   2      dataLenN units -> bytes shift (2 = dwords)
//  OP_READ     5'd0   opcode routed to RdDCS
//  OP_WRITE    5'd1   opcode routed to WrDCS
// PORTS
//  clock            in   1    core clock
//  reset            in   1    synchronous, active-high
//  fifoEmpty        in   1    WorkQueue empty
//  fifoData         in   112  WorkQueue data, valid the cycle after fifoPop
//  fifoPop          out  1    one-cycle pop strobe
//  RdDCSChipSelect_o/RdDCSWrite_o  out 1   RdDCS master strobes
//  RdDCSAddress_o   out  8    RdDCS register offset
//  RdDCSWriteData_o out  32   RdDCS write data
//  RdDCSByteEnable_o out 4    RdDCS byte enables, always 4'hF
//  RdDCSRead_o      out  1    RdDCS read strobe, tied 0
//  RdDCSWaitRequest_i in 1    RdDCS stall
//  WrDCS*           --   --   same set as RdDCS*, for the write DMA
//  done             out  1    one-cycle pulse when an entry completes
//  doneTid          out  8    TID of completed entry, valid while done
//  busy             out  1    high whenever state != IDLE
//  errCount         out  16   dropped-entry count (see CONFIGURATION)
// BEHAVIOUR
//  Entry fields:
//   opcode[111:107] dataNum[106:104] TID[103:96]
//   len0[95:88] len1[87:80] len2[79:72] len3[71:64] base[63:0]
//  Reset values: all outputs 0; state=IDLE; offset=0; errCount=0.
//  FSM:
//   IDLE: !fifoEmpty -> fifoPop=1 for 1 cycle -> LOAD.
//   LOAD: latch fifoData; seg=0; offset=0 -> CHECK.
//   CHECK: drop the entry (no bus traffic, errCount+1, no done) -> IDLE when
//          opcode not OP_READ/OP_WRITE, or dataNum==0, or dataNum>4.
//          Otherwise -> DESC, beat=0.
//   DESC: one write per beat to the selected master only; the other master stays idle (all 0).
//    beat0 addr 0x00 data (base+offset)[31:0]
//    beat1 addr 0x04 data (base+offset)[63:32]
//    beat2 addr 0x08 data {16'd0, lenN<<LEN_SHIFT} (16-bit field)
//    beat3 addr 0x0C data {TID, 13'd0, last, seg[1:0], 8'd0}; last = (seg==dataNum-1)
//   Beat handshake: ChipSelect=Write=1 and address/data held stable until the cycle
//    with WaitRequest==0. That cycle completes the beat; the next beat is presented the following cycle.
//   After beat3 completes: offset += lenN<<LEN_SHIFT (64-bit add, wraps mod 2^64).
//    If last -> DONE; else seg+1, beat=0.
//   DONE: done=1, doneTid=TID for exactly 1 cycle -> IDLE.
//  Throughput: min 4 cycles per descriptor. Entry overhead: IDLE+LOAD+CHECK+DONE = 4 cycles.
//  fifoPop is never asserted outside IDLE. fifoEmpty is ignored while busy.
//  lenN==0 is legal: length word is 0 and offset is unchanged.
//  Reset mid-burst: bus strobes drop the same cycle reset is sampled; the entry in flight is lost.
//  errCount saturates at 16'hFFFF.
// CONFIGURATION
//  WQD_ERR_CNT_EN defined: errCount is live as described above.
//  WQD_ERR_CNT_EN undefined: errCount tied 16'd0, no counter flops.
//   Drops still occur silently with identical timing.
// TESTING
//  1. Reset, then opcode=1, dataNum=1, TID=8'h5A, len0=8'h10, base=64'h1_0000_1000
//     -> WrDCS writes 0x00=0x00001000, 0x04=0x1, 0x08=0x40, 0x0C=0x5A000400;
//        done with doneTid=0x5A; RdDCS idle.
//  2. opcode=0, dataNum=3, len={4,8,2}, base=0x100
//     -> RdDCS segment addrs 0x100, 0x110, 0x130; last bit set only on seg 2.
//  3. WaitRequest held high 5 cycles on beat1 -> addr 0x04 and its data stable all 6 cycles;
//     exactly 1 accepted write per beat.
//  4. Entries opcode=7, dataNum=0, and dataNum=5 -> no bus writes, no done, errCount=3
//     (0 with macro undefined).
//  5. Two entries queued back-to-back -> second fifoPop only after first done; 2 done pulses, TIDs in order.
//  6. reset asserted during beat2 of seg1 -> strobes 0 next edge, busy=0;
//     next entry processes correctly from seg0.

Source files
------------

// File: rtl/work_queue_dispatcher.sv
// ---------------------------------------------------------------------------
// work_queue_dispatcher
//
// Pops 112-bit work-queue entries and turns each one into 1..4 DMA
// descriptors. Every descriptor is four 32-bit register writes on one
// Avalon-MM master: RdDCS for read opcodes, WrDCS for write opcodes.
// A malformed entry is dropped without any bus traffic.
//
// Entry layout:
//   [111:107] opcode  [106:104] dataNum  [103:96] TID
//   [95:88] len0  [87:80] len1  [79:72] len2  [71:64] len3  [63:0] base
//
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   fifoEmpty/fifoData    WorkQueue pop side (data valid the cycle after pop)
//   fifoPop               one-cycle pop strobe, only in IDLE
//   RdDCS*_o / RdDCS*_i   Avalon-MM master to the read DMA descriptor slave
//   WrDCS*_o / WrDCS*_i   Avalon-MM master to the write DMA descriptor slave
//   done / doneTid        one-cycle completion pulse with the entry TID
//   busy                  high whenever the FSM is not in IDLE
//   errCount              saturating dropped-entry counter
//
// Build option:
//   WQD_ERR_CNT_EN  defined   -> errCount is a live saturating counter
//                   undefined -> errCount tied to 0, no counter flops
// ---------------------------------------------------------------------------
module work_queue_dispatcher #(
    parameter int         LEN_SHIFT = 2,
    parameter logic [4:0] OP_READ   = 5'd0,
    parameter logic [4:0] OP_WRITE  = 5'd1
) (
    input  logic         clock,
    input  logic         reset,

    input  logic         fifoEmpty,
    input  logic [111:0] fifoData,
    output logic         fifoPop,

    output logic         RdDCSChipSelect_o,
    output logic         RdDCSWrite_o,
    output logic [7:0]   RdDCSAddress_o,
    output logic [31:0]  RdDCSWriteData_o,
    output logic [3:0]   RdDCSByteEnable_o,
    output logic         RdDCSRead_o,
    input  logic         RdDCSWaitRequest_i,

    output logic         WrDCSChipSelect_o,
    output logic         WrDCSWrite_o,
    output logic [7:0]   WrDCSAddress_o,
    output logic [31:0]  WrDCSWriteData_o,
    output logic [3:0]   WrDCSByteEnable_o,
    output logic         WrDCSRead_o,
    input  logic         WrDCSWaitRequest_i,

    output logic         done,
    output logic [7:0]   doneTid,
    output logic         busy,
    output logic [15:0]  errCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DESC,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [111:0]  entry;
    logic [1:0]    seg;
    logic [1:0]    beat;
    logic [63:0]   offset;

    // Decoded fields of the latched entry
    logic [4:0]    opcode;
    logic [2:0]    data_num;
    logic [7:0]    tid;
    logic [63:0]   base;
    logic [7:0]    len_sel;
    logic [15:0]   len_ext;
    logic [15:0]   len_bytes;
    logic [63:0]   seg_addr;
    logic          is_read;
    logic          entry_ok;
    logic          last;
    logic          bus_wait;
    logic [7:0]    beat_addr;
    logic [31:0]   beat_data;

    assign opcode   = entry[111:107];
    assign data_num = entry[106:104];
    assign tid      = entry[103:96];
    assign base     = entry[63:0];

    always_comb begin
        len_sel = entry[95:88];
        unique case (seg)
            2'd0: len_sel = entry[95:88];
            2'd1: len_sel = entry[87:80];
            2'd2: len_sel = entry[79:72];
            2'd3: len_sel = entry[71:64];
            default: len_sel = entry[95:88];
        endcase
    end

    // Length is carried in a 16-bit field; shifting inside 16 bits keeps the
    // scaled value intact for any LEN_SHIFT up to 8.
    assign len_ext   = {8'd0, len_sel};
    assign len_bytes = len_ext << LEN_SHIFT;
    assign seg_addr  = base + offset;

    assign is_read  = (opcode == OP_READ);
    assign entry_ok = (is_read || (opcode == OP_WRITE)) &&
                      (data_num != 3'd0) && (data_num <= 3'd4);
    assign last     = ({1'b0, seg} == (data_num - 3'd1));
    assign bus_wait = is_read ? RdDCSWaitRequest_i : WrDCSWaitRequest_i;

    assign beat_addr = {4'd0, beat, 2'b00};

    always_comb begin
        beat_data = 32'd0;
        unique case (beat)
            2'd0: beat_data = seg_addr[31:0];
            2'd1: beat_data = seg_addr[63:32];
            2'd2: beat_data = {16'd0, len_bytes};
            2'd3: beat_data = {tid, 13'd0, last, seg, 8'd0};
            default: beat_data = 32'd0;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign RdDCSRead_o = 1'b0;
    assign WrDCSRead_o = 1'b0;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and outputs. Everything is forced low while reset is high so
    // bus strobes drop in the very cycle reset is sampled. Byte enables are
    // 4'hF whenever a master is writing and 0 while that master is idle.
    always_comb begin
        state_nxt          = state;
        fifoPop            = 1'b0;
        done               = 1'b0;
        doneTid            = 8'd0;
        RdDCSChipSelect_o  = 1'b0;
        RdDCSWrite_o       = 1'b0;
        RdDCSAddress_o     = 8'd0;
        RdDCSWriteData_o   = 32'd0;
        RdDCSByteEnable_o  = 4'd0;
        WrDCSChipSelect_o  = 1'b0;
        WrDCSWrite_o       = 1'b0;
        WrDCSAddress_o     = 8'd0;
        WrDCSWriteData_o   = 32'd0;
        WrDCSByteEnable_o  = 4'd0;

        if (!reset) begin
            unique case (state)
                S_IDLE: begin
                    if (!fifoEmpty) begin
                        fifoPop   = 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
                S_LOAD: state_nxt = S_CHECK;
                S_CHECK: state_nxt = entry_ok ? S_DESC : S_IDLE;
                S_DESC: begin
                    if (is_read) begin
                        RdDCSChipSelect_o = 1'b1;
                        RdDCSWrite_o      = 1'b1;
                        RdDCSAddress_o    = beat_addr;
                        RdDCSWriteData_o  = beat_data;
                        RdDCSByteEnable_o = 4'hF;
                    end else begin
                        WrDCSChipSelect_o = 1'b1;
                        WrDCSWrite_o      = 1'b1;
                        WrDCSAddress_o    = beat_addr;
                        WrDCSWriteData_o  = beat_data;
                        WrDCSByteEnable_o = 4'hF;
                    end
                    if (!bus_wait && (beat == 2'd3) && last)
                        state_nxt = S_DONE;
                end
                S_DONE: begin
                    done      = 1'b1;
                    doneTid   = tid;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Entry latch and segment/beat/offset walk
    always_ff @(posedge clock) begin
        if (reset) begin
            entry  <= '0;
            seg    <= 2'd0;
            beat   <= 2'd0;
            offset <= 64'd0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    entry  <= fifoData;
                    seg    <= 2'd0;
                    beat   <= 2'd0;
                    offset <= 64'd0;
                end
                S_CHECK: beat <= 2'd0;
                S_DESC: begin
                    if (!bus_wait) begin
                        if (beat == 2'd3) begin
                            offset <= offset + {48'd0, len_bytes};
                            beat   <= 2'd0;
                            if (!last) seg <= seg + 2'd1;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WQD_ERR_CNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            err_cnt <= 16'd0;
        else if ((state == S_CHECK) && !entry_ok && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end

    assign errCount = err_cnt;
`else
    assign errCount = 16'd0;
`endif

endmodule
